// File: rtl/lab_fun_sweep.sv
// Exhaustive truth-table sweeper: latches a function table and a reference table,
// walks every input vector once and accumulates minterm and mismatch statistics.
module lab_fun_sweep #(
    parameter int N = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic              step_mode_i,
    input  logic              step_i,
    input  logic [(1<<N)-1:0] tt_i,
    input  logic [(1<<N)-1:0] exp_i,
    output logic [N-1:0]      vec_out_o,
    output logic              f_out_o,
    output logic              valid_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [N:0]        ones_cnt_o,
    output logic [N:0]        mism_cnt_o,
    output logic              fail_o,
    output logic [N-1:0]      first_fail_o
);
    localparam int DEPTH = 1 << N;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     idx_q, idx_d;
    logic [DEPTH-1:0] tt_q, tt_d;
    logic [DEPTH-1:0] exp_q, exp_d;
    logic             mode_q, mode_d;
    logic [N-1:0]     vec_q, vec_d;
    logic             f_q, f_d;
    logic             valid_q, valid_d;
    logic [N:0]       ones_q, ones_d;
    logic [N:0]       mism_q, mism_d;
    logic             fail_q, fail_d;
    logic [N-1:0]     ff_q, ff_d;

    logic adv;
    logic f_cur;
    logic miss_cur;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            tt_q    <= '0;
            exp_q   <= '0;
            mode_q  <= 1'b0;
            vec_q   <= '0;
            f_q     <= 1'b0;
            valid_q <= 1'b0;
            ones_q  <= '0;
            mism_q  <= '0;
            fail_q  <= 1'b0;
            ff_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tt_q    <= tt_d;
            exp_q   <= exp_d;
            mode_q  <= mode_d;
            vec_q   <= vec_d;
            f_q     <= f_d;
            valid_q <= valid_d;
            ones_q  <= ones_d;
            mism_q  <= mism_d;
            fail_q  <= fail_d;
            ff_q    <= ff_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        tt_d     = tt_q;
        exp_d    = exp_q;
        mode_d   = mode_q;
        vec_d    = vec_q;
        f_d      = f_q;
        valid_d  = 1'b0;
        ones_d   = ones_q;
        mism_d   = mism_q;
        fail_d   = fail_q;
        ff_d     = ff_q;
        adv      = !mode_q || step_i;
        f_cur    = tt_q[idx_q];
        miss_cur = tt_q[idx_q] ^ exp_q[idx_q];

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    tt_d    = tt_i;
                    exp_d   = exp_i;
                    mode_d  = step_mode_i;
                    idx_d   = '0;
                    ones_d  = '0;
                    mism_d  = '0;
                    fail_d  = 1'b0;
                    ff_d    = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (adv) begin
                    vec_d   = idx_q;
                    f_d     = f_cur;
                    valid_d = 1'b1;
                    ones_d  = ones_q + (N+1)'(f_cur);
                    if (miss_cur) begin
                        mism_d = mism_q + (N+1)'(1);
                        fail_d = 1'b1;
                        // Only the first mismatch of the sweep is recorded.
                        if (!fail_q) ff_d = idx_q;
                    end
                    if (idx_q == {N{1'b1}}) state_d = S_DONE;
                    else                    idx_d   = idx_q + N'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        vec_out_o    = vec_q;
        f_out_o      = f_q;
        valid_o      = valid_q;
        busy_o       = (state_q == S_RUN);
        done_o       = (state_q == S_DONE);
        ones_cnt_o   = ones_q;
        mism_cnt_o   = mism_q;
        fail_o       = fail_q;
        first_fail_o = ff_q;
    end

endmodule

// File: tb/tb_lab_fun_sweep.sv
// Self-checking bench for lab_fun_sweep: N=4 sweeps in free-run and step mode,
// reset mid-sweep, restart from DONE, plus an N=1 boundary instance.
module tb_lab_fun_sweep;
    localparam int N = 4;
    localparam int D = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, start, step_mode, step;
    logic [D-1:0] tt, exp_t;
    logic [N-1:0] vec_out, first_fail;
    logic         f_out, valid, busy, done, fail;
    logic [N:0]   ones_cnt, mism_cnt;

    logic       start1, step_mode1, step1;
    logic [1:0] tt1, exp1;
    logic       vec1, f1, valid1, busy1, done1, fail1, ff1;
    logic [1:0] ones1, mism1;

    int checks = 0;
    int errors = 0;

    lab_fun_sweep #(.N(N)) u_dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .step_mode_i(step_mode),
        .step_i(step), .tt_i(tt), .exp_i(exp_t), .vec_out_o(vec_out), .f_out_o(f_out),
        .valid_o(valid), .busy_o(busy), .done_o(done), .ones_cnt_o(ones_cnt),
        .mism_cnt_o(mism_cnt), .fail_o(fail), .first_fail_o(first_fail)
    );

    lab_fun_sweep #(.N(1)) u_dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start1), .step_mode_i(step_mode1),
        .step_i(step1), .tt_i(tt1), .exp_i(exp1), .vec_out_o(vec1), .f_out_o(f1),
        .valid_o(valid1), .busy_o(busy1), .done_o(done1), .ones_cnt_o(ones1),
        .mism_cnt_o(mism1), .fail_o(fail1), .first_fail_o(ff1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: plain popcount / lowest-set-bit over the tables.
    function automatic int ref_pop(input logic [D-1:0] m);
        int c = 0;
        for (int i = 0; i < D; i++) c += int'(m[i]);
        return c;
    endfunction

    function automatic int ref_first(input logic [D-1:0] m);
        for (int i = 0; i < D; i++) if (m[i]) return i;
        return 0;
    endfunction

    task automatic chk_results(input string tag, input logic [D-1:0] t, input logic [D-1:0] e);
        chk({tag, "/ones"}, ones_cnt, ref_pop(t));
        chk({tag, "/mism"}, mism_cnt, ref_pop(t ^ e));
        chk({tag, "/fail"}, fail, (t != e));
        chk({tag, "/first"}, first_fail, ref_first(t ^ e));
    endtask

    task automatic sweep_free(input string tag, input logic [D-1:0] t, input logic [D-1:0] e,
                              input bit poke);
        int  nval;
        int  cyc;
        bit  seen;
        nval = 0; cyc = 0; seen = 0;
        tt = t; exp_t = e; step_mode = 0; step = 0; start = 1;
        tick();
        start = 0; tt = $urandom; exp_t = $urandom; step_mode = 1;
        chk({tag, "/busy"}, busy, 1);
        chk({tag, "/done_clr"}, done, 0);
        chk({tag, "/valid0"}, valid, 0);
        while (!seen && cyc < 40) begin
            start = (poke && cyc == 4);
            tick();
            cyc++;
            if (valid) begin
                chk({tag, "/vec"}, vec_out, nval);
                if (nval < D) chk({tag, "/f"}, f_out, t[nval]);
                nval++;
            end
            if (done) seen = 1;
        end
        start = 0;
        chk({tag, "/done_seen"}, seen, 1);
        chk({tag, "/last_valid"}, valid, 1);
        chk({tag, "/nval"}, nval, D);
        chk({tag, "/latency"}, cyc, D);
        chk_results(tag, t, e);
        tick();
        chk({tag, "/valid_off"}, valid, 0);
        chk({tag, "/done_hold"}, done, 1);
        chk({tag, "/busy_off"}, busy, 0);
        chk({tag, "/vec_hold"}, vec_out, D - 1);
        chk_results({tag, "/hold"}, t, e);
    endtask

    initial begin
        logic [D-1:0] t;
        int  nval;
        int  cyc;
        bit  seen;

        rst_n = 0; start = 0; step_mode = 0; step = 0; tt = '0; exp_t = '0;
        start1 = 0; step_mode1 = 0; step1 = 0; tt1 = '0; exp1 = '0;
        tick(); tick();
        rst_n = 1;
        chk("rst/valid", valid, 0);
        chk("rst/busy", busy, 0);
        chk("rst/done", done, 0);
        chk("rst/ones", ones_cnt, 0);
        chk("rst/vec", vec_out, 0);
        tick();
        chk("idle/busy", busy, 0);

        sweep_free("adad", 16'hADAD, 16'hADAD, 0);
        chk("adad/ones10", ones_cnt, 10);
        sweep_free("mism1", 16'hADAD, 16'hADA9, 0);
        chk("mism1/first2", first_fail, 2);
        sweep_free("mism_all", 16'hADAD, ~16'hADAD, 0);
        chk("mism_all/16", mism_cnt, 16);

        // Step mode: the step on the start edge must not advance.
        t = D'($urandom);
        tt = t; exp_t = t; step_mode = 1; step = 1; start = 1;
        tick();
        start = 0; step = 0; step_mode = 0; tt = ~t;
        chk("step/valid_start", valid, 0);
        chk("step/busy", busy, 1);
        for (int p = 0; p < 3; p++) begin
            repeat (2) begin
                tick();
                chk("step/idle", valid, 0);
            end
            step = 1;
            tick();
            step = 0;
            chk("step/pulse_valid", valid, 1);
            chk("step/pulse_vec", vec_out, p);
            chk("step/pulse_f", f_out, t[p]);
        end
        tick();
        chk("step/idle_after", valid, 0);
        step = 1; nval = 3; cyc = 0; seen = 0;
        while (!seen && cyc < 30) begin
            tick();
            cyc++;
            if (valid) begin
                chk("step/held_vec", vec_out, nval);
                if (nval < D) chk("step/held_f", f_out, t[nval]);
                nval++;
            end
            else chk("step/held_gap", valid, 1);
            if (done) seen = 1;
        end
        step = 0;
        chk("step/done_seen", seen, 1);
        chk("step/nval", nval, D);
        chk_results("step", t, t);

        for (int r = 0; r < 3; r++) begin
            sweep_free("rand_poke", D'($urandom), D'($urandom), 1);
        end

        // Reset in the middle of a sweep.
        t = D'($urandom);
        tt = t; exp_t = ~t; step_mode = 0; start = 1;
        tick();
        start = 0; cyc = 0;
        while (!(valid && vec_out == 4'd7) && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("midrst/reached7", vec_out, 7);
        rst_n = 0;
        tick();
        rst_n = 1;
        chk("midrst/vec", vec_out, 0);
        chk("midrst/f", f_out, 0);
        chk("midrst/valid", valid, 0);
        chk("midrst/busy", busy, 0);
        chk("midrst/done", done, 0);
        chk("midrst/ones", ones_cnt, 0);
        chk("midrst/mism", mism_cnt, 0);
        chk("midrst/fail", fail, 0);
        chk("midrst/first", first_fail, 0);
        tick();
        chk("midrst/idle", busy, 0);
        chk("midrst/idle_valid", valid, 0);
        sweep_free("after_rst", 16'hFFFF, 16'hFFFF, 0);
        chk("after_rst/ones16", ones_cnt, 16);

        // N=1 boundary instance.
        tt1 = 2'b10; exp1 = 2'b10; start1 = 1;
        tick();
        start1 = 0; tt1 = 2'b01;
        chk("n1/busy", busy1, 1);
        chk("n1/valid0", valid1, 0);
        tick();
        chk("n1/v0_valid", valid1, 1);
        chk("n1/v0_vec", vec1, 0);
        chk("n1/v0_f", f1, 0);
        chk("n1/v0_done", done1, 0);
        tick();
        chk("n1/v1_valid", valid1, 1);
        chk("n1/v1_vec", vec1, 1);
        chk("n1/v1_f", f1, 1);
        chk("n1/done", done1, 1);
        chk("n1/ones", ones1, 1);
        chk("n1/mism", mism1, 0);
        chk("n1/fail", fail1, 0);
        tick();
        chk("n1/valid_off", valid1, 0);
        chk("n1/done_hold", done1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
